// File: rtl/qracc_ctrl_if.sv
// qracc_ctrl_if: host-side command/response bundle for the QR compute macro
// sequencer.
//   cmd_valid/cmd_ready  : request handshake (host -> controller)
//   cmd_op               : 0=WRITE, 1=READ, 2=MAC, 3=reserved
//   cmd_addr             : row for WRITE/READ
//   cmd_wdata            : row data for WRITE
//   cmd_vec              : binary activation vector for MAC
//   resp_valid/resp_ready: response handshake (controller -> host)
//   resp_data            : READ sense data (LSBs) or MAC ADC codes
//   resp_err             : command rejected (bad address or reserved op)
// modport master is the host side, modport slave is the controller side.
interface qracc_ctrl_if #(
  parameter int numRows    = 128,
  parameter int numCols    = 8,
  parameter int numAdcBits = 4
);
  localparam int AW = $clog2(numRows);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [AW-1:0]                cmd_addr;
  logic [numCols-1:0]           cmd_wdata;
  logic [numRows-1:0]           cmd_vec;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [numAdcBits*numCols-1:0] resp_data;
  logic                         resp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_vec, resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_vec, resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/qracc_ctrl.sv
// qracc_ctrl: sequences the analog interface of the QR compute macro (switch
// matrix, SRAM, ADC) for one host command at a time and returns the captured
// sense-amp or ADC result.
// Ports:
//   CLK, RST         : clock, asynchronous active-high reset
//   bus (slave)      : command/response handshake, see qracc_ctrl_if
//   VDR/VSS/VRST_SEL : row switch matrix selects (+ complements *B)
//   WL               : word lines (one-hot or zero)
//   PCH, WR_DATA, WRITE, CSEL, SAEN : SRAM column controls
//   NF, M2A, R2A     : ADC column controls (+ complements *B)
//   SA_OUT           : sense-amp data, registered by the macro
//   ADC_OUT          : ADC codes
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | cmd_ready=1, waiting for a command
// W_PCH     | write: precharge bit lines
// W_WL      | write: word line + write drivers on
// R_PCH     | read: precharge bit lines
// R_SENSE   | read: word line + sense amps enabled
// R_CAP     | read: controls idle, capture SA_OUT
// M_RST     | MAC: reset MBL through VRST, ADC reset
// M_DRIVE   | MAC: drive MBL from vec for settleCycles cycles
// M_CAP     | MAC: keep drives, capture ADC_OUT
// RESP      | response held until resp_ready
module qracc_ctrl #(
  parameter int numRows      = 128,
  parameter int numCols      = 8,
  parameter int numAdcBits   = 4,
  parameter int settleCycles = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  qracc_ctrl_if.slave                   bus,
  output logic [numRows-1:0]            VDR_SEL,
  output logic [numRows-1:0]            VDR_SELB,
  output logic [numRows-1:0]            VSS_SEL,
  output logic [numRows-1:0]            VSS_SELB,
  output logic [numRows-1:0]            VRST_SEL,
  output logic [numRows-1:0]            VRST_SELB,
  output logic [numRows-1:0]            WL,
  output logic [numCols-1:0]            PCH,
  output logic [numCols-1:0]            WR_DATA,
  output logic [numCols-1:0]            WRITE,
  output logic [numCols-1:0]            CSEL,
  output logic [numCols-1:0]            SAEN,
  output logic [numCols-1:0]            NF,
  output logic [numCols-1:0]            NFB,
  output logic [numCols-1:0]            M2A,
  output logic [numCols-1:0]            M2AB,
  output logic [numCols-1:0]            R2A,
  output logic [numCols-1:0]            R2AB,
  input  logic [numCols-1:0]            SA_OUT,
  input  logic [numAdcBits*numCols-1:0] ADC_OUT
);
  localparam int AW = $clog2(numRows);
  localparam int DW = numAdcBits * numCols;
  localparam logic [7:0] SETTLE = 8'(settleCycles);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_MAC   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_PCH   = 4'd1;
  localparam logic [3:0] S_W_WL    = 4'd2;
  localparam logic [3:0] S_R_PCH   = 4'd3;
  localparam logic [3:0] S_R_SENSE = 4'd4;
  localparam logic [3:0] S_R_CAP   = 4'd5;
  localparam logic [3:0] S_M_RST   = 4'd6;
  localparam logic [3:0] S_M_DRIVE = 4'd7;
  localparam logic [3:0] S_M_CAP   = 4'd8;
  localparam logic [3:0] S_RESP    = 4'd9;

  logic [3:0]         r_state, w_state;
  logic [7:0]         r_cnt, w_cnt;
  logic [AW-1:0]      r_addr;
  logic [numCols-1:0] r_wdata;
  logic [numRows-1:0] r_vec;
  logic [DW-1:0]      r_resp_data;
  logic               r_resp_err;

  logic [numRows-1:0] r_vdr_sel, r_vdr_selb, r_vss_sel, r_vss_selb;
  logic [numRows-1:0] r_vrst_sel, r_vrst_selb, r_wl;
  logic [numCols-1:0] r_pch, r_wr_data, r_write, r_csel, r_saen;
  logic [numCols-1:0] r_nf, r_nfb, r_m2a, r_m2ab, r_r2a, r_r2ab;

  logic [numRows-1:0] w_vdr_sel, w_vss_sel, w_vrst_sel, w_wl;
  logic [numCols-1:0] w_pch, w_wr_data, w_write, w_csel, w_saen;
  logic [numCols-1:0] w_nf, w_m2a, w_r2a;

  logic w_accept, w_addr_oor, w_cmd_err;

  // With a power-of-two row count every encodable address is in range.
  if ((1 << AW) > numRows) begin : g_addr_chk
    assign w_addr_oor = (bus.cmd_addr >= AW'(numRows));
  end else begin : g_addr_nochk
    assign w_addr_oor = 1'b0;
  end

  assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_cmd_err = (bus.cmd_op == OP_RSVD) ||
                     (w_addr_oor && (bus.cmd_op != OP_MAC));

  // Next-cycle analog controls are decoded from the state being entered so
  // that every analog output comes straight from a flop.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_vdr_sel  = '0;
    w_vss_sel  = '0;
    w_vrst_sel = '0;
    w_wl       = '0;
    w_pch      = '0;
    w_wr_data  = '0;
    w_write    = '0;
    w_csel     = '0;
    w_saen     = '0;
    w_nf       = '0;
    w_m2a      = '0;
    w_r2a      = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (w_cmd_err) begin
            w_state = S_RESP;
          end else if (bus.cmd_op == OP_WRITE) begin
            w_state = S_W_PCH;
            w_pch   = '1;
            w_csel  = '1;
          end else if (bus.cmd_op == OP_READ) begin
            w_state = S_R_PCH;
            w_pch   = '1;
            w_csel  = '1;
          end else begin
            w_state    = S_M_RST;
            w_vrst_sel = '1;
            w_r2a      = '1;
          end
        end
      end
      S_W_PCH: begin
        w_state        = S_W_WL;
        w_pch          = '1;
        w_csel         = '1;
        w_write        = '1;
        w_wl[r_addr]   = 1'b1;
        w_wr_data      = r_wdata;
      end
      S_W_WL:    w_state = S_RESP;
      S_R_PCH: begin
        w_state      = S_R_SENSE;
        w_pch        = '1;
        w_csel       = '1;
        w_saen       = '1;
        w_wl[r_addr] = 1'b1;
      end
      S_R_SENSE: w_state = S_R_CAP;
      S_R_CAP:   w_state = S_RESP;
      S_M_RST: begin
        w_state   = S_M_DRIVE;
        w_cnt     = SETTLE;
        w_vdr_sel = r_vec;
        w_vss_sel = ~r_vec;
        w_nf      = '1;
        w_m2a     = '1;
      end
      S_M_DRIVE: begin
        // Drives stay on through M_CAP so the ADC samples a settled MBL.
        w_vdr_sel = r_vec;
        w_vss_sel = ~r_vec;
        w_nf      = '1;
        w_m2a     = '1;
        if (r_cnt <= 8'd1) w_state = S_M_CAP;
        else               w_cnt   = r_cnt - 8'd1;
      end
      S_M_CAP:   w_state = S_RESP;
      S_RESP:    if (bus.resp_ready) w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_vec       <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_vdr_sel   <= '0;
      r_vdr_selb  <= '1;
      r_vss_sel   <= '0;
      r_vss_selb  <= '1;
      r_vrst_sel  <= '0;
      r_vrst_selb <= '1;
      r_wl        <= '0;
      r_pch       <= '0;
      r_wr_data   <= '0;
      r_write     <= '0;
      r_csel      <= '0;
      r_saen      <= '0;
      r_nf        <= '0;
      r_nfb       <= '1;
      r_m2a       <= '0;
      r_m2ab      <= '1;
      r_r2a       <= '0;
      r_r2ab      <= '1;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      // Complements get their own flops so both rails switch on the same edge.
      r_vdr_sel   <= w_vdr_sel;
      r_vdr_selb  <= ~w_vdr_sel;
      r_vss_sel   <= w_vss_sel;
      r_vss_selb  <= ~w_vss_sel;
      r_vrst_sel  <= w_vrst_sel;
      r_vrst_selb <= ~w_vrst_sel;
      r_wl        <= w_wl;
      r_pch       <= w_pch;
      r_wr_data   <= w_wr_data;
      r_write     <= w_write;
      r_csel      <= w_csel;
      r_saen      <= w_saen;
      r_nf        <= w_nf;
      r_nfb       <= ~w_nf;
      r_m2a       <= w_m2a;
      r_m2ab      <= ~w_m2a;
      r_r2a       <= w_r2a;
      r_r2ab      <= ~w_r2a;
      if (w_accept) begin
        r_addr      <= bus.cmd_addr;
        r_wdata     <= bus.cmd_wdata;
        r_vec       <= bus.cmd_vec;
        r_resp_err  <= w_cmd_err;
        r_resp_data <= '0;
      end else if (r_state == S_R_CAP) begin
        r_resp_data <= DW'(SA_OUT);
      end else if (r_state == S_M_CAP) begin
        r_resp_data <= ADC_OUT;
      end else if ((r_state == S_RESP) && bus.resp_ready) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;

  assign VDR_SEL   = r_vdr_sel;
  assign VDR_SELB  = r_vdr_selb;
  assign VSS_SEL   = r_vss_sel;
  assign VSS_SELB  = r_vss_selb;
  assign VRST_SEL  = r_vrst_sel;
  assign VRST_SELB = r_vrst_selb;
  assign WL        = r_wl;
  assign PCH       = r_pch;
  assign WR_DATA   = r_wr_data;
  assign WRITE     = r_write;
  assign CSEL      = r_csel;
  assign SAEN      = r_saen;
  assign NF        = r_nf;
  assign NFB       = r_nfb;
  assign M2A       = r_m2a;
  assign M2AB      = r_m2ab;
  assign R2A       = r_r2a;
  assign R2AB      = r_r2ab;
endmodule

// File: tb/tb_qracc_ctrl.sv
// tb_qracc_ctrl: bench for qracc_ctrl with a behavioural macro stand-in
// (row memory, registered sense amps, random ADC codes) and a reference
// model of expected responses and latencies.
module tb_qracc_ctrl;
  localparam int NR = 128;
  localparam int NC = 8;
  localparam int NB = 4;
  localparam int ST = 4;
  localparam int DW = NB * NC;
  localparam int AW = $clog2(NR);

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic [NR-1:0] VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB, WL;
  logic [NC-1:0] PCH, WR_DATA, WRITE, CSEL, SAEN, NF, NFB, M2A, M2AB, R2A, R2AB;
  logic [NC-1:0] SA_OUT = '0;
  logic [DW-1:0] ADC_OUT = '0;
  logic [DW-1:0] adc_at_edge = '0;
  logic [NC-1:0] mac_mem [NR] = '{default: '0};
  logic [NC-1:0] ref_mem [NR];

  int n_checks = 0;
  int n_err    = 0;

  qracc_ctrl_if #(.numRows(NR), .numCols(NC), .numAdcBits(NB)) bus ();

  qracc_ctrl #(.numRows(NR), .numCols(NC), .numAdcBits(NB), .settleCycles(ST)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .VDR_SEL(VDR_SEL), .VDR_SELB(VDR_SELB), .VSS_SEL(VSS_SEL), .VSS_SELB(VSS_SELB),
    .VRST_SEL(VRST_SEL), .VRST_SELB(VRST_SELB), .WL(WL),
    .PCH(PCH), .WR_DATA(WR_DATA), .WRITE(WRITE), .CSEL(CSEL), .SAEN(SAEN),
    .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB), .R2A(R2A), .R2AB(R2AB),
    .SA_OUT(SA_OUT), .ADC_OUT(ADC_OUT)
  );

  always #5 CLK = ~CLK;

  // Macro stand-in: rows written on the clock while WRITE is on, sense amps
  // registered on the clock while SAEN is on.
  always @(posedge CLK) begin
    for (int r = 0; r < NR; r++) begin
      if (WL[r]) begin
        if (|WRITE) mac_mem[r] <= (mac_mem[r] & ~(WRITE & CSEL)) | (WR_DATA & WRITE & CSEL);
        if (|SAEN)  SA_OUT <= mac_mem[r] & SAEN & CSEL;
      end
    end
  end

  always @(negedge CLK) ADC_OUT <= DW'($urandom);
  always @(posedge CLK) adc_at_edge <= ADC_OUT;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [NC-1:0] cinv(input logic [NC-1:0] x);
    return ~x;
  endfunction

  task automatic chk(input string tag, input logic [NR-1:0] obs, input logic [NR-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and check the always-true properties.
  task automatic tick();
    @(negedge CLK);
    chk("vdr_b",  VDR_SELB,  ~VDR_SEL);
    chk("vss_b",  VSS_SELB,  ~VSS_SEL);
    chk("vrst_b", VRST_SELB, ~VRST_SEL);
    chk("nf_b",   NR'(NFB),  NR'(cinv(NF)));
    chk("m2a_b",  NR'(M2AB), NR'(cinv(M2A)));
    chk("r2a_b",  NR'(R2AB), NR'(cinv(R2A)));
    chk("wl_onehot0", NR'($onehot0(WL)), 1);
    chk("write_and_saen", NR'((|WRITE) && (|SAEN)), 0);
    chk("vdr_and_vss", VDR_SEL & VSS_SEL, 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input int addr, input logic [NC-1:0] wd,
                         input logic [NR-1:0] vec, input int hold, input int exp_lat,
                         input logic exp_err, input logic [DW-1:0] exp_data, input logic exp_adc,
                         output int vdr_cyc, output logic wl_any,
                         output logic [NR-1:0] wl_wr, output logic [NC-1:0] write_wr);
    int n;
    logic [DW-1:0] expd;
    tick();
    chk("cmd_ready_idle", NR'(bus.cmd_ready), 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_addr   = AW'(addr);
    bus.cmd_wdata  = wd;
    bus.cmd_vec    = vec;
    bus.resp_ready = 1'b0;
    @(posedge CLK);
    tick();
    n = 1;
    vdr_cyc = 0;
    wl_any = 1'b0;
    wl_wr = '0;
    write_wr = '0;
    forever begin
      // Noise on the command port while busy must be ignored.
      bus.cmd_op    = 2'($urandom);
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = NC'($urandom);
      bus.cmd_vec   = {$urandom, $urandom, $urandom, $urandom};
      if (vec != '0 && VDR_SEL === vec && VSS_SEL === ~vec && M2A === '1) vdr_cyc++;
      if (WL != '0) wl_any = 1'b1;
      if (WRITE != '0) begin
        wl_wr = WL;
        write_wr = WRITE;
      end
      if (bus.resp_valid === 1'b1 || n >= 400) break;
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    chk("latency", NR'(n), NR'(exp_lat));
    expd = exp_adc ? adc_at_edge : exp_data;
    chk("resp_data", NR'(bus.resp_data), NR'(expd));
    chk("resp_err", NR'(bus.resp_err), NR'(exp_err));
    repeat (hold) begin
      tick();
      chk("hold_valid", NR'(bus.resp_valid), 1);
      chk("hold_data", NR'(bus.resp_data), NR'(expd));
      chk("hold_cmd_ready", NR'(bus.cmd_ready), 0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("resp_done", NR'(bus.resp_valid), 0);
    chk("ready_after", NR'(bus.cmd_ready), 1);
    chk("resp_data_clr", NR'(bus.resp_data), 0);
  endtask

  initial begin
    int vc;
    logic wa;
    logic [NR-1:0] wlw;
    logic [NC-1:0] wrw;
    logic [1:0] op;
    int addr;
    logic [NC-1:0] wd;
    logic [NR-1:0] vec;

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_vec    = '0;
    bus.resp_ready = 1'b0;
    for (int r = 0; r < NR; r++) ref_mem[r] = '0;

    tick();
    tick();
    chk("rst_cmd_ready", NR'(bus.cmd_ready), 1);
    chk("rst_resp_valid", NR'(bus.resp_valid), 0);
    chk("rst_resp_data", NR'(bus.resp_data), 0);
    chk("rst_resp_err", NR'(bus.resp_err), 0);
    chk("rst_vdr_selb", VDR_SELB, '1);
    chk("rst_wl", WL, 0);
    chk("rst_pch", NR'(PCH), 0);
    chk("rst_vrst", VRST_SEL, 0);
    chk("rst_m2ab", NR'(M2AB), NR'(8'hFF));
    RST = 1'b0;

    // Write row 5 then read it back with the response held off 10 cycles.
    run_cmd(2'd0, 5, 8'hA5, '0, 0, 3, 1'b0, '0, 1'b0, vc, wa, wlw, wrw);
    ref_mem[5] = 8'hA5;
    chk("w_wl_onehot", wlw, 128'(1) << 5);
    chk("w_write_all", NR'(wrw), NR'(8'hFF));
    run_cmd(2'd1, 5, '0, '0, 10, 4, 1'b0, DW'(8'hA5), 1'b0, vc, wa, wlw, wrw);

    // MAC over rows 0..3.
    for (int r = 0; r < 4; r++) begin
      run_cmd(2'd0, r, 8'hFF, '0, 0, 3, 1'b0, '0, 1'b0, vc, wa, wlw, wrw);
      ref_mem[r] = 8'hFF;
    end
    run_cmd(2'd2, 0, '0, 128'hF, 0, ST + 3, 1'b0, '0, 1'b1, vc, wa, wlw, wrw);
    chk("mac_vdr_cycles", NR'(vc), NR'(ST + 1));
    chk("mac_no_wl", NR'(wa), 0);

    // Reserved op is rejected without analog activity.
    run_cmd(2'd3, 9, 8'h11, '0, 2, 1, 1'b1, '0, 1'b0, vc, wa, wlw, wrw);
    chk("err_no_wl", NR'(wa), 0);

    // Reset in the middle of M_DRIVE.
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_vec   = 128'hF0;
    @(posedge CLK);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("pre_rst_vdr", VDR_SEL, 128'hF0);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_vdr", VDR_SEL, 0);
    chk("rst_mid_vdrb", VDR_SELB, '1);
    chk("rst_mid_m2a", NR'(M2A), 0);
    chk("rst_mid_resp_valid", NR'(bus.resp_valid), 0);
    tick();
    RST = 1'b0;
    tick();
    chk("post_rst_cmd_ready", NR'(bus.cmd_ready), 1);
    chk("post_rst_resp_valid", NR'(bus.resp_valid), 0);
    chk("post_rst_vss", VSS_SEL, 0);
    run_cmd(2'd0, 1, 8'h3C, '0, 0, 3, 1'b0, '0, 1'b0, vc, wa, wlw, wrw);
    ref_mem[1] = 8'h3C;
    run_cmd(2'd1, 1, '0, '0, 0, 4, 1'b0, DW'(8'h3C), 1'b0, vc, wa, wlw, wrw);

    // Random command mix against the reference model.
    for (int i = 0; i < 24; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = int'($urandom_range(0, NR - 1));
      wd   = NC'($urandom);
      vec  = {$urandom, $urandom, $urandom, $urandom};
      case (op)
        2'd0: begin
          run_cmd(op, addr, wd, '0, int'($urandom_range(0, 3)), 3, 1'b0, '0, 1'b0, vc, wa, wlw, wrw);
          ref_mem[addr] = wd;
          chk("rnd_w_wl", wlw, 128'(1) << addr);
        end
        2'd1: run_cmd(op, addr, wd, '0, int'($urandom_range(0, 3)), 4, 1'b0,
                      DW'(ref_mem[addr]), 1'b0, vc, wa, wlw, wrw);
        2'd2: begin
          run_cmd(op, addr, wd, vec, int'($urandom_range(0, 3)), ST + 3, 1'b0, '0, 1'b1,
                  vc, wa, wlw, wrw);
          chk("rnd_mac_vdr_cycles", NR'(vc), NR'(ST + 1));
          chk("rnd_mac_no_wl", NR'(wa), 0);
        end
        default: begin
          run_cmd(op, addr, wd, '0, int'($urandom_range(0, 3)), 1, 1'b1, '0, 1'b0, vc, wa, wlw, wrw);
          chk("rnd_err_no_wl", NR'(wa), 0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
